// File: rtl/sigmo_err_acc_if.sv
// sigmo_err_acc_if: sample stream carrying a sigmoid tag, approximation and reference
interface sigmo_err_acc_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [11:0] x;
  logic [13:0] y;
  logic [13:0] yexact;
  modport master(output in_valid, in_last, x, y, yexact, input in_ready);
  modport slave(input in_valid, in_last, x, y, yexact, output in_ready);
endinterface

// File: rtl/sigmo_err_acc.sv
// sigmo_err_acc: accumulates abs/squared/worst-case error of a sigmoid approximation
module sigmo_err_acc #(
  parameter int MAXN = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  sigmo_err_acc_if.slave      s,
  output logic [25:0]         sum_abs,
  output logic [39:0]         sum_sq,
  output logic [13:0]         wc_err,
  output logic [11:0]         wc_x,
  output logic [12:0]         count,
  output logic                ovf,
  output logic                done
);
  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;
  state_t      state;
  logic        dc;
  logic        xfer;
  logic [14:0] d;
  logic [14:0] nd;
  logic [13:0] e_in;
  logic        v1, v2;
  logic [13:0] e1, e2;
  logic [11:0] x1, x2;
  logic [27:0] sq2;
  assign s.in_ready = state == ACC;
  assign xfer = s.in_valid && s.in_ready;
  assign d = {s.y[13], s.y} - {s.yexact[13], s.yexact};
  assign nd = -d;
  assign e_in = d[14] ? nd[13:0] : d[13:0];
  always_ff @(posedge clk) begin
    if (rst || start) begin
      state   <= rst ? IDLE : ACC;
      dc      <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      e1      <= '0;
      x1      <= '0;
      e2      <= '0;
      x2      <= '0;
      sq2     <= '0;
      sum_abs <= '0;
      sum_sq  <= '0;
      wc_err  <= '0;
      wc_x    <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      v1 <= xfer;
      if (xfer) begin
        e1 <= e_in;
        x1 <= s.x;
      end
      v2  <= v1;
      sq2 <= {14'b0, e1} * {14'b0, e1};
      e2  <= e1;
      x2  <= x1;
      // samples past MAXN only flag overflow and leave the results untouched
      if (v2) begin
        if (count == 13'(MAXN))
          ovf <= 1'b1;
        else begin
          sum_abs <= sum_abs + 26'(e2);
          sum_sq  <= sum_sq + 40'(sq2);
          count   <= count + 13'd1;
          if (e2 > wc_err) begin
            wc_err <= e2;
            wc_x   <= x2;
          end
        end
      end
      case (state)
        ACC: if (xfer && s.in_last) begin
          state <= DRAIN;
          dc    <= 1'b0;
        end
        DRAIN: if (dc) begin
          state <= DONE;
          done  <= 1'b1;
        end else
          dc <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sigmo_err_acc.sv
// tb_sigmo_err_acc: directed table and sequence checks for sigmo_err_acc
module tb_sigmo_err_acc;
  logic        clk = 0;
  logic        rst;
  logic        start;
  logic [25:0] sum_abs;
  logic [39:0] sum_sq;
  logic [13:0] wc_err;
  logic [11:0] wc_x;
  logic [12:0] count;
  logic        ovf;
  logic        done;
  int          checks = 0;
  int          errors = 0;
  sigmo_err_acc_if bus();
  sigmo_err_acc #(.MAXN(4096)) dut (
    .clk(clk), .rst(rst), .start(start), .s(bus),
    .sum_abs(sum_abs), .sum_sq(sum_sq), .wc_err(wc_err), .wc_x(wc_x),
    .count(count), .ovf(ovf), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [11:0] x;
    logic [13:0] y;
    logic [13:0] ye;
    logic [25:0] ea;
    logic [39:0] es;
    logic [13:0] ew;
    logic [11:0] ex;
  } vec_t;
  vec_t tv[5];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [39:0] a, input logic [39:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, a, e);
    end
  endtask
  task automatic chk_res(input string t, input logic [25:0] ea, input logic [39:0] es,
                         input logic [13:0] ew, input logic [11:0] ex, input logic [12:0] ec,
                         input logic eo, input logic ed);
    chk({t, ".sum_abs"}, 40'(sum_abs), 40'(ea));
    chk({t, ".sum_sq"}, sum_sq, es);
    chk({t, ".wc_err"}, 40'(wc_err), 40'(ew));
    chk({t, ".wc_x"}, 40'(wc_x), 40'(ex));
    chk({t, ".count"}, 40'(count), 40'(ec));
    chk({t, ".ovf"}, 40'(ovf), 40'(eo));
    chk({t, ".done"}, 40'(done), 40'(ed));
  endtask
  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic send(input logic [11:0] x, input logic [13:0] y, input logic [13:0] ye, input logic last);
    bus.in_valid = 1;
    bus.in_last = last;
    bus.x = x;
    bus.y = y;
    bus.yexact = ye;
    tick();
    bus.in_valid = 0;
    bus.in_last = 0;
  endtask
  task automatic drain(input string t);
    chk({t, ".done_e1"}, 40'(done), 40'd0);
    tick();
    chk({t, ".done_e2"}, 40'(done), 40'd0);
    tick();
    chk({t, ".done_e3"}, 40'(done), 40'd1);
  endtask
  initial begin
    tv[0] = '{12'd3, 14'd100, 14'd100, 26'd0, 40'd0, 14'd0, 12'd0};
    tv[1] = '{12'h800, 14'd8191, 14'h2000, 26'd16383, 40'd268402689, 14'd16383, 12'h800};
    tv[2] = '{12'd2047, 14'h2000, 14'd8191, 26'd16383, 40'd268402689, 14'd16383, 12'd2047};
    tv[3] = '{12'd10, 14'(-5), 14'(-1), 26'd4, 40'd16, 14'd4, 12'd10};
    tv[4] = '{12'hFFF, 14'd0, 14'd1, 26'd1, 40'd1, 14'd1, 12'hFFF};
    rst = 1;
    start = 0;
    bus.in_valid = 0;
    bus.in_last = 0;
    bus.x = 0;
    bus.y = 0;
    bus.yexact = 0;
    tick();
    tick();
    rst = 0;
    bus.in_valid = 1;
    bus.y = 14'd500;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle.in_ready", 40'(bus.in_ready), 40'd0);
    end
    bus.in_valid = 0;
    chk_res("idle", 0, 0, 0, 0, 0, 0, 0);
    do_start();
    chk("acc.in_ready", 40'(bus.in_ready), 40'd1);
    send(12'd5, 14'd100, 14'd90, 0);
    send(12'(-7), 14'(-20), 14'd30, 1);
    chk("drain.in_ready", 40'(bus.in_ready), 40'd0);
    drain("basic");
    chk_res("basic", 26'd60, 40'd2600, 14'd50, 12'(-7), 13'd2, 0, 1);
    bus.in_valid = 1;
    bus.in_last = 1;
    bus.x = 12'd99;
    bus.y = 14'd8000;
    bus.yexact = 14'(-8000);
    for (int i = 0; i < 4; i++) tick();
    bus.in_valid = 0;
    bus.in_last = 0;
    chk("done.in_ready", 40'(bus.in_ready), 40'd0);
    chk_res("stable", 26'd60, 40'd2600, 14'd50, 12'(-7), 13'd2, 0, 1);
    do_start();
    chk_res("cleared", 0, 0, 0, 0, 0, 0, 0);
    send(12'd1, 14'd7, 14'd0, 0);
    send(12'd2, 14'd0, 14'd7, 1);
    drain("tie");
    chk_res("tie", 26'd14, 40'd98, 14'd7, 12'd1, 13'd2, 0, 1);
    for (int i = 0; i < 5; i++) begin
      do_start();
      send(tv[i].x, tv[i].y, tv[i].ye, 1);
      drain($sformatf("vec%0d", i));
      chk_res($sformatf("vec%0d", i), tv[i].ea, tv[i].es, tv[i].ew, tv[i].ex, 13'd1, 0, 1);
    end
    do_start();
    for (int i = 0; i < 4097; i++) send(12'(i + 1), 14'd8191, 14'h2000, i == 4096);
    drain("full");
    chk_res("full", 26'd67104768, 40'd1099377414144, 14'd16383, 12'd1, 13'd4096, 1, 1);
    do_start();
    send(12'd1, 14'd50, 14'd0, 0);
    send(12'd2, 14'd60, 14'd0, 0);
    send(12'd3, 14'd70, 14'd0, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("rst.in_ready", 40'(bus.in_ready), 40'd0);
    tick();
    tick();
    tick();
    chk_res("rstmid", 0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    start = 1;
    tick();
    rst = 0;
    start = 0;
    chk("rstovr.in_ready", 40'(bus.in_ready), 40'd0);
    do_start();
    send(12'd4, 14'd200, 14'd0, 0);
    send(12'd5, 14'd300, 14'd0, 0);
    do_start();
    chk_res("restart", 0, 0, 0, 0, 0, 0, 0);
    send(12'd9, 14'd3, 14'd0, 1);
    drain("restart");
    chk_res("restart", 26'd3, 40'd9, 14'd3, 12'd9, 13'd1, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
